reg_dump_sequencer: RTL and testbench

REG_DUMP_SEQUENCER -- requirements
Module: reg_dump_sequencer

---
 rtl/reg_dump_sequencer_pkg.sv | 24 ++
 rtl/reg_dump_sequencer_dump_counter.sv | 62 ++++++
 rtl/reg_dump_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_reg_dump_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_sequencer_pkg.sv
// Shared state encoding and defaults for the register-dump sequencer.
// Defining REG_DUMP_PC_EN adds a PC_SEND state that appends the PC word after the last register.
package reg_dump_sequencer_pkg;

    localparam int DRAIN_CYCLES_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SEND    = 3'd4,
`ifdef REG_DUMP_PC_EN
        ST_PC_SEND = 3'd5,
`endif
        ST_DONE    = 3'd6
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_dump_sequencer_dump_counter.sv
// Word index and pipeline-drain counter for the register-dump sequencer.
// The index carries one extra bit so the last register is detected without wrapping.
module dump_counter
    import reg_dump_sequencer_pkg::*;
#(
    parameter int REG_SIZE     = 5,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                index_clr_i,
    input  logic                index_inc_i,
    input  logic                drain_clr_i,
    input  logic                drain_inc_i,
    output logic [REG_SIZE-1:0] index_next_o,
    output logic                index_last_o,
    output logic                drain_done_o
);

    localparam int IDX_W   = REG_SIZE + 1;
    localparam int DRAIN_W = cnt_width(DRAIN_CYCLES);

    localparam logic [IDX_W-1:0]   LAST_INDEX = IDX_W'((1 << REG_SIZE) - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    logic [IDX_W-1:0]   index_q, index_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    always_comb begin
        index_d = index_q;
        if (index_clr_i) begin
            index_d = '0;
        end else if (index_inc_i) begin
            index_d = index_q + IDX_W'(1);
        end
    end

    // The drain count saturates at its terminal value so a long DRAIN can never wrap.
    always_comb begin
        drain_d = drain_q;
        if (drain_clr_i) begin
            drain_d = '0;
        end else if (drain_inc_i && (drain_q != DRAIN_LAST)) begin
            drain_d = drain_q + DRAIN_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            index_q <= '0;
            drain_q <= '0;
        end else begin
            index_q <= index_d;
            drain_q <= drain_d;
        end
    end

    assign index_next_o = index_d[REG_SIZE-1:0];
    assign index_last_o = (index_q == LAST_INDEX);
    assign drain_done_o = (drain_q == DRAIN_LAST);

endmodule

// File: rtl/reg_dump_sequencer.sv
// Stalls the pipeline, reads every register-bank entry and streams it out over a valid/ready handshake.
// Optional feature macro: REG_DUMP_PC_EN appends the current PC as a final word.
module reg_dump_sequencer
    import reg_dump_sequencer_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int REG_SIZE     = 5,
    parameter int PC_SIZE      = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [DATA_SIZE-1:0] i_rb_data,
    input  logic [PC_SIZE-1:0]   i_pc,
    input  logic                 i_ready,
    output logic                 o_pipeline_enable,
    output logic                 o_unit_control_enable,
    output logic                 o_rb_enable,
    output logic                 o_rb_read_enable,
    output logic [REG_SIZE-1:0]  o_rb_read_addr,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_done
);

    state_e               state_q, state_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 rb_read_q, rb_read_d;
    logic [REG_SIZE-1:0]  addr_q, addr_d;
    logic                 enables_q, enables_d;

    logic                 index_clr, index_inc, drain_clr, drain_inc;
    logic [REG_SIZE-1:0]  index_next;
    logic                 index_last, drain_done;

`ifdef REG_DUMP_PC_EN
    logic [DATA_SIZE-1:0] pc_word;
    assign pc_word = DATA_SIZE'(i_pc);
`else
    logic unused_pc;
    assign unused_pc = ^i_pc;
`endif

    dump_counter #(
        .REG_SIZE     (REG_SIZE),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_dump_counter (
        .clk_i        (i_clock),
        .rst_ni       (i_reset),
        .index_clr_i  (index_clr),
        .index_inc_i  (index_inc),
        .drain_clr_i  (drain_clr),
        .drain_inc_i  (drain_inc),
        .index_next_o (index_next),
        .index_last_o (index_last),
        .drain_done_o (drain_done)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        index_clr = 1'b0;
        index_inc = 1'b0;
        drain_clr = 1'b0;
        drain_inc = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d   = ST_DRAIN;
                    index_clr = 1'b1;
                    drain_clr = 1'b1;
                end
            end
            ST_DRAIN: begin
                drain_inc = 1'b1;
                if (drain_done) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_SEND;
                data_d  = i_rb_data;
                valid_d = 1'b1;
            end
            ST_SEND: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    if (index_last) begin
`ifdef REG_DUMP_PC_EN
                        state_d = ST_PC_SEND;
                        data_d  = pc_word;
                        valid_d = 1'b1;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        index_inc = 1'b1;
                        state_d   = ST_READ;
                    end
                end
            end
`ifdef REG_DUMP_PC_EN
            ST_PC_SEND: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Abort overrides any handshake in the same cycle; the pending word is not counted.
        if ((state_q != ST_IDLE) && i_abort) begin
            state_d   = ST_IDLE;
            valid_d   = 1'b0;
            index_inc = 1'b0;
        end

        // Outputs are registered from the next state so they line up with the state they describe.
        rb_read_d = (state_d == ST_READ);
        if (state_d == ST_READ) begin
            addr_d = index_next;
        end
        done_d    = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE);
        enables_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            rb_read_q <= 1'b0;
            addr_q    <= '0;
            enables_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            rb_read_q <= rb_read_d;
            addr_q    <= addr_d;
            enables_q <= enables_d;
        end
    end

    assign o_pipeline_enable     = enables_q;
    assign o_unit_control_enable = enables_q;
    assign o_rb_enable           = rb_read_q;
    assign o_rb_read_enable      = rb_read_q;
    assign o_rb_read_addr        = addr_q;
    assign o_data                = data_q;
    assign o_valid               = valid_q;
    assign o_busy                = busy_q;
    assign o_done                = done_q;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Randomized bench for reg_dump_sequencer: a register-bank model feeds reads and a word list predicts each dump.
// Builds with or without REG_DUMP_PC_EN; the expected word list follows the macro.
module tb_reg_dump_sequencer;

    localparam int DATA_SIZE = 32;
    localparam int REG_SIZE  = 5;
    localparam int PC_SIZE   = 32;
    localparam int DRAIN     = 4;
    localparam int NREG      = 1 << REG_SIZE;
    localparam int BUDGET    = 5000;
`ifdef REG_DUMP_PC_EN
    localparam int N_WORDS   = NREG + 1;
`else
    localparam int N_WORDS   = NREG;
`endif

    localparam int MODE_NORMAL = 0;
    localparam int MODE_STALL  = 1;
    localparam int MODE_ABORT  = 2;
    localparam int MODE_START  = 3;

    logic                 i_clock;
    logic                 i_reset;
    logic                 i_start;
    logic                 i_abort;
    logic [DATA_SIZE-1:0] i_rb_data = '0;
    logic [PC_SIZE-1:0]   i_pc;
    logic                 i_ready;
    logic                 o_pipeline_enable;
    logic                 o_unit_control_enable;
    logic                 o_rb_enable;
    logic                 o_rb_read_enable;
    logic [REG_SIZE-1:0]  o_rb_read_addr;
    logic [DATA_SIZE-1:0] o_data;
    logic                 o_valid;
    logic                 o_busy;
    logic                 o_done;

    logic [DATA_SIZE-1:0] bank [NREG];
    logic [DATA_SIZE-1:0] got_q [$];
    logic [DATA_SIZE-1:0] exp_q [$];
    int                   done_cnt, rd_cnt, en_viol, stab_viol;
    int                   n_checks, n_errors;
    bit                   hold_prev;
    logic [DATA_SIZE-1:0] hold_data;

    reg_dump_sequencer #(
        .DATA_SIZE    (DATA_SIZE),
        .REG_SIZE     (REG_SIZE),
        .PC_SIZE      (PC_SIZE),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .i_clock               (i_clock),
        .i_reset               (i_reset),
        .i_start               (i_start),
        .i_abort               (i_abort),
        .i_rb_data             (i_rb_data),
        .i_pc                  (i_pc),
        .i_ready               (i_ready),
        .o_pipeline_enable     (o_pipeline_enable),
        .o_unit_control_enable (o_unit_control_enable),
        .o_rb_enable           (o_rb_enable),
        .o_rb_read_enable      (o_rb_read_enable),
        .o_rb_read_addr        (o_rb_read_addr),
        .o_data                (o_data),
        .o_valid               (o_valid),
        .o_busy                (o_busy),
        .o_done                (o_done)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // Register bank: data appears one cycle after the read strobe.
    always @(posedge i_clock) begin
        if (o_rb_read_enable) i_rb_data <= bank[o_rb_read_addr];
    end

    // Passive observer: collects handshaken words and protocol violations.
    always @(negedge i_clock) begin
        if (!i_reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && (!o_valid || (o_data !== hold_data))) stab_viol++;
            hold_prev = o_valid && !i_ready && !i_abort;
            hold_data = o_data;
            if (o_valid && i_ready && !i_abort) got_q.push_back(o_data);
            if (o_done) done_cnt++;
            if (o_rb_read_enable) rd_cnt++;
            if (o_busy ? (o_pipeline_enable || o_unit_control_enable)
                       : !(o_pipeline_enable && o_unit_control_enable)) en_viol++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ":data"},    64'(o_data), 64'd0);
        check({tag, ":valid"},   64'(o_valid), 64'd0);
        check({tag, ":done"},    64'(o_done), 64'd0);
        check({tag, ":busy"},    64'(o_busy), 64'd0);
        check({tag, ":rb_en"},   64'(o_rb_enable), 64'd0);
        check({tag, ":rb_rd"},   64'(o_rb_read_enable), 64'd0);
        check({tag, ":rb_addr"}, 64'(o_rb_read_addr), 64'd0);
        check({tag, ":pipe_en"}, 64'(o_pipeline_enable), 64'd1);
        check({tag, ":uc_en"},   64'(o_unit_control_enable), 64'd1);
    endtask

    task automatic clear_observer();
        got_q.delete();
        done_cnt  = 0;
        rd_cnt    = 0;
        en_viol   = 0;
        stab_viol = 0;
    endtask

    task automatic run_dump(input string name, input int mode, input int ready_pct);
        int  cycles, stall, first_rd, exp_len, exp_rd, exp_done;
        bit  aborted, abort_seen, start_sent;
        cycles = 0; stall = 0; first_rd = -1;
        aborted = 1'b0; abort_seen = 1'b0; start_sent = 1'b0;

        exp_q.delete();
        for (int k = 0; k < NREG; k++) exp_q.push_back(bank[k]);
        if (N_WORDS > NREG) exp_q.push_back(DATA_SIZE'(i_pc));
        exp_len  = (mode == MODE_ABORT) ? 10 : N_WORDS;
        exp_rd   = (mode == MODE_ABORT) ? 11 : NREG;
        exp_done = (mode == MODE_ABORT) ? 0 : 1;

        clear_observer();
        @(posedge i_clock); #1;
        check({name, ":idle_before"}, 64'(o_busy), 64'd0);
        i_start = 1'b1;
        @(posedge i_clock); #1;
        i_start = 1'b0;

        while (cycles < BUDGET) begin
            if (aborted && !abort_seen) begin
                abort_seen = 1'b1;
                check({name, ":abort_busy"},  64'(o_busy), 64'd0);
                check({name, ":abort_valid"}, 64'(o_valid), 64'd0);
                check({name, ":abort_pipe"},  64'(o_pipeline_enable), 64'd1);
                check({name, ":abort_uc"},    64'(o_unit_control_enable), 64'd1);
            end
            if (!o_busy) break;
            if (o_rb_read_enable && first_rd < 0) first_rd = cycles;
            i_abort = 1'b0;
            i_start = 1'b0;
            i_ready = ($urandom_range(99) < ready_pct);
            if (mode == MODE_STALL && o_valid && got_q.size() == 3 && stall < 5) begin
                i_ready = 1'b0;
                stall++;
            end
            if (mode == MODE_ABORT && o_valid && got_q.size() == 10 && !aborted) begin
                i_abort = 1'b1;
                aborted = 1'b1;
            end
            if (mode == MODE_START && o_valid && !start_sent) begin
                i_start    = 1'b1;
                start_sent = 1'b1;
            end
            @(negedge i_clock);
            if (mode == MODE_STALL && stall > 0 && !i_ready && got_q.size() == 3) begin
                check({name, ":stall_data"},  64'(o_data), 64'(exp_q[3]));
                check({name, ":stall_valid"}, 64'(o_valid), 64'd1);
            end
            @(posedge i_clock); #1;
            cycles++;
        end
        i_ready = 1'b0;
        i_abort = 1'b0;
        i_start = 1'b0;
        if (cycles >= BUDGET) check({name, ":timeout"}, 64'd1, 64'd0);
        repeat (3) @(posedge i_clock);
        #1;

        check({name, ":drain_len"}, 64'(first_rd), 64'(DRAIN));
        check({name, ":words"}, 64'(got_q.size()), 64'(exp_len));
        for (int i = 0; i < got_q.size() && i < exp_len; i++)
            check($sformatf("%s:word%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
        check({name, ":done_pulses"}, 64'(done_cnt), 64'(exp_done));
        check({name, ":reads"},       64'(rd_cnt), 64'(exp_rd));
        check({name, ":enables"},     64'(en_viol), 64'd0);
        check({name, ":stable"},      64'(stab_viol), 64'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        hold_prev = 1'b0;
        i_reset   = 1'b0;
        i_start   = 1'b0;
        i_abort   = 1'b0;
        i_ready   = 1'b0;
        i_pc      = '0;
        clear_observer();

        #12;
        check_reset_values("por");
        @(negedge i_clock);
        i_reset = 1'b1;

        for (int k = 0; k < NREG; k++) bank[k] = DATA_SIZE'(k + 100);
        i_pc = 32'h0000_0040;
        run_dump("incr", MODE_NORMAL, 100);
        run_dump("stall3", MODE_STALL, 100);
        run_dump("abort10", MODE_ABORT, 70);
        run_dump("start_in_send", MODE_START, 60);

        // Reset asserted in the middle of DRAIN must take effect with no clock edge.
        clear_observer();
        @(posedge i_clock); #1;
        i_start = 1'b1;
        @(posedge i_clock); #1;
        i_start = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clock); #3;
        i_reset = 1'b0;
        #1;
        check_reset_values("drain_rst");
        @(negedge i_clock);
        i_reset = 1'b1;
        repeat (10) @(posedge i_clock);
        #1;
        i_ready = 1'b0;
        check("drain_rst:words_after", 64'(got_q.size()), 64'd0);
        check("drain_rst:done_after",  64'(done_cnt), 64'd0);
        check("drain_rst:busy_after",  64'(o_busy), 64'd0);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NREG; k++) bank[k] = $urandom;
            i_pc = $urandom;
            run_dump($sformatf("rand%0d", r), MODE_NORMAL, int'($urandom_range(100, 20)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
